// File: rtl/traffic_demand_detector_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | traffic_demand_detector_if                                                 |
// | Sensor / light-code inputs and demand / starvation outputs of the detector.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface traffic_demand_detector_if;
   logic       sensor1;
   logic       sensor2;
   logic       sensor3;
   logic       sensor4;
   logic [3:0] Road1;
   logic [3:0] Road2;
   logic [3:0] Road3;
   logic [3:0] Road4;
   logic       c1;
   logic       c2;
   logic       c3;
   logic       c4;
   logic [3:0] starved;

   modport master (
      output sensor1, sensor2, sensor3, sensor4,
      output Road1, Road2, Road3, Road4,
      input  c1, c2, c3, c4,
      input  starved
   );

   modport slave (
      input  sensor1, sensor2, sensor3, sensor4,
      input  Road1, Road2, Road3, Road4,
      output c1, c2, c3, c4,
      output starved
   );
endinterface
`default_nettype wire

// File: rtl/traffic_demand_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | traffic_demand_detector                                                    |
// | Debounced, latched per-road demand requests with per-road starvation flags.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module traffic_demand_detector #(
   parameter int DEBOUNCE = 4,
   parameter int MAX_WAIT = 200
) (
   input  logic                      clk,
   input  logic                      clear,
   traffic_demand_detector_if.slave  bus
);

   localparam logic [3:0] c_DB_LAST  = 4'(DEBOUNCE - 1);
   localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);
   localparam logic [3:0] c_GREEN    = 4'd1;

   logic [3:0] w_sensor;
   logic [3:0] w_green;
   logic [3:0] w_c;
   logic [3:0] w_starved;

   assign w_sensor = {bus.sensor4, bus.sensor3, bus.sensor2, bus.sensor1};
   assign w_green  = {bus.Road4 == c_GREEN, bus.Road3 == c_GREEN,
                      bus.Road2 == c_GREEN, bus.Road1 == c_GREEN};

   generate
      for (genvar g = 0; g < 4; g++) begin : g_road
         logic       r_sync1;
         logic       r_sync2;
         logic       r_p;
         logic [3:0] r_cnt;
         logic       r_c;
         logic [7:0] r_wait;
         logic       r_starved;
         logic [7:0] w_wait_next;

         // Starved flag is registered from the next counter value so it
         // tracks the counter on the same edge.
         always_comb begin
            w_wait_next = r_wait;
            if (!r_c || w_green[g])
               w_wait_next = '0;
            else if (r_wait != c_MAX_WAIT)
               w_wait_next = r_wait + 8'd1;
         end

         always_ff @(posedge clk) begin
            if (clear) begin
               r_sync1   <= 1'b0;
               r_sync2   <= 1'b0;
               r_p       <= 1'b0;
               r_cnt     <= '0;
               r_c       <= 1'b0;
               r_wait    <= '0;
               r_starved <= 1'b0;
            end else begin
               r_sync1 <= w_sensor[g];
               r_sync2 <= r_sync1;
               if (r_sync2 != r_p) begin
                  if (r_cnt == c_DB_LAST) begin
                     r_p   <= ~r_p;
                     r_cnt <= '0;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end else begin
                  r_cnt <= '0;
               end
               r_c       <= r_p | (r_c & ~w_green[g]);
               r_wait    <= w_wait_next;
               r_starved <= (w_wait_next == c_MAX_WAIT);
            end
         end

         assign w_c[g]       = r_c;
         assign w_starved[g] = r_starved;
      end
   endgenerate

   assign bus.c1      = w_c[0];
   assign bus.c2      = w_c[1];
   assign bus.c3      = w_c[2];
   assign bus.c4      = w_c[3];
   assign bus.starved = w_starved;

endmodule
`default_nettype wire

// File: tb/tb_traffic_demand_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_traffic_demand_detector                                                 |
// | Directed bench for traffic_demand_detector (DEBOUNCE=4, MAX_WAIT=5).       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_traffic_demand_detector;

   localparam int c_DEBOUNCE = 4;
   localparam int c_MAX_WAIT = 5;

   logic clk;
   logic clear;
   int   n_checks;
   int   n_fail;

   traffic_demand_detector_if bus_if ();

   traffic_demand_detector #(
      .DEBOUNCE (c_DEBOUNCE),
      .MAX_WAIT (c_MAX_WAIT)
   ) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, then sample 1 time unit after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] cvec();
      return {bus_if.c4, bus_if.c3, bus_if.c2, bus_if.c1};
   endfunction

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clear          = 1'b1;
      bus_if.sensor1 = 1'b0;
      bus_if.sensor2 = 1'b0;
      bus_if.sensor3 = 1'b0;
      bus_if.sensor4 = 1'b0;
      bus_if.Road1   = 4'd1;
      bus_if.Road2   = 4'd0;
      bus_if.Road3   = 4'd0;
      bus_if.Road4   = 4'd0;
      step(2);
      check("reset_c", 8'(cvec()), 8'h0);
      check("reset_starved", 8'(bus_if.starved), 8'h0);
      clear = 1'b0;

      // Clean arrival on road 2, then yellow keeps it waiting
      bus_if.sensor2 = 1'b1;
      step(6);
      check("arrive_c2_edge6", 8'(cvec()), 8'h0);
      step(1);
      check("arrive_c_edge7", 8'(cvec()), 8'h2);
      bus_if.Road2 = 4'd2;
      step(4);
      check("yellow_c2_hold", 8'(bus_if.c2), 8'h1);
      check("yellow_not_starved", 8'(bus_if.starved[1]), 8'h0);
      step(1);
      check("yellow_starved", 8'(bus_if.starved[1]), 8'h1);
      bus_if.Road2 = 4'd1;
      step(1);
      check("green_p_keeps_c2", 8'(bus_if.c2), 8'h1);
      check("green_clears_starved2", 8'(bus_if.starved[1]), 8'h0);
      bus_if.sensor2 = 1'b0;
      step(6);
      check("retire_c2_edge6", 8'(bus_if.c2), 8'h1);
      step(1);
      check("retire_c2_edge7", 8'(bus_if.c2), 8'h0);
      bus_if.Road2 = 4'd0;

      // Glitch rejection on road 3
      bus_if.sensor3 = 1'b1;
      step(3);
      bus_if.sensor3 = 1'b0;
      step(10);
      check("glitch3_rejected", 8'(bus_if.c3), 8'h0);
      bus_if.sensor3 = 1'b1;
      step(4);
      bus_if.sensor3 = 1'b0;
      step(2);
      check("pulse4_c3_edge6", 8'(bus_if.c3), 8'h0);
      step(1);
      check("pulse4_c3_edge7", 8'(bus_if.c3), 8'h1);

      // Latch and retire on road 4
      bus_if.sensor4 = 1'b1;
      step(10);
      bus_if.sensor4 = 1'b0;
      step(10);
      check("latch_c4", 8'(bus_if.c4), 8'h1);
      bus_if.Road4 = 4'd1;
      step(1);
      check("retire_c4", 8'(bus_if.c4), 8'h0);
      bus_if.sensor4 = 1'b1;
      step(7);
      check("green_arrive_c4", 8'(bus_if.c4), 8'h1);
      step(3);
      check("green_hold_c4", 8'(bus_if.c4), 8'h1);
      check("green_no_starve4", 8'(bus_if.starved[3]), 8'h0);

      // Starvation on road 1
      bus_if.Road1   = 4'd0;
      bus_if.sensor1 = 1'b1;
      step(6);
      check("starve_c1_edge6", 8'(bus_if.c1), 8'h0);
      step(1);
      check("starve_c1_edge7", 8'(bus_if.c1), 8'h1);
      check("starve0_at_rise", 8'(bus_if.starved[0]), 8'h0);
      step(4);
      check("starve0_edge4", 8'(bus_if.starved[0]), 8'h0);
      step(1);
      check("starve0_edge5", 8'(bus_if.starved[0]), 8'h1);
      step(10);
      check("starve0_saturate", 8'(bus_if.starved[0]), 8'h1);
      bus_if.Road1 = 4'd1;
      step(1);
      check("starve0_green_clear", 8'(bus_if.starved[0]), 8'h0);
      check("starve_c1_green_p", 8'(bus_if.c1), 8'h1);

      // Clear mid-operation
      bus_if.Road1   = 4'd0;
      bus_if.Road4   = 4'd0;
      bus_if.sensor2 = 1'b1;
      bus_if.sensor3 = 1'b1;
      step(8);
      check("pre_clear_c", 8'(cvec()), 8'hf);
      clear = 1'b1;
      step(1);
      check("clear_c", 8'(cvec()), 8'h0);
      check("clear_starved", 8'(bus_if.starved), 8'h0);
      clear = 1'b0;
      step(c_DEBOUNCE + 2);
      check("recover_c_edge6", 8'(cvec()), 8'h0);
      step(1);
      check("recover_c_edge7", 8'(cvec()), 8'hf);
      check("recover_starved", 8'(bus_if.starved), 8'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/traffic_demand_detector.md
Name: traffic_demand_detector

Overview:
- Vehicle-detection front end for the four-road traffic light controller.
- Turns raw, noisy loop-sensor inputs into clean, latched per-road demand requests c1..c4, which drive the controller's request inputs.
- Watches the controller's Road1..Road4 light codes (red=4'd0, green=4'd1, yellow=4'd2) so it can retire a road's demand once that road has been served.
- Flags roads that have waited too long for service.

Parameters:
- DEBOUNCE, 4, consecutive synchronized cycles needed to change a road's filtered presence (legal range 1..15).
- MAX_WAIT, 200, saturation and threshold value of each road's wait counter (legal range 1..255).

Ports:
- clk  input  1  system clock.
- clear  input  1  synchronous, active-high reset.
- sensor1..sensor4  input  1 each  raw loop-detector inputs, asynchronous to clk.
- Road1..Road4  input  4 each  light codes from the controller; only 4'd1 means green, every other code means not green.
- c1..c4  output  1 each  registered demand request per road.
- starved  output  4  bit n-1 high while road n's wait counter equals MAX_WAIT.

Behaviour:
- Reset: clear is sampled on posedge clk and overrides all other logic. The following all go to 0 at that edge:
  - synchronizer flops
  - debounce counters
  - presence flags
  - c1..c4
  - wait counters
  - starved
- Synchronizer: each sensorN passes through two flops, sync1 then sync2. There is no combinational path from sensorN to any output.
- Debounce, per road, with a 4-bit counter cnt and a presence flag p:
  - If sync2 != p: cnt increments. When cnt == DEBOUNCE-1 at an edge, p toggles and cnt returns to 0 at that edge.
  - If sync2 == p: cnt returns to 0.
  - A glitch shorter than DEBOUNCE synchronized cycles never changes p.
- Demand latch, per road, registered:
  - c_next = p | (c & ~(RoadN == 4'd1)).
  - Demand sets once presence is detected and holds after the vehicle leaves the loop.
  - While the road is green, c simply follows p; demand retires when the road is green and the loop is empty.
  - Set wins over clear: a green road with p=1 keeps c=1.
- Latency:
  - Rising: sensor held high from before edge 1, with DEBOUNCE=4, gives sync2=1 after edge 2, p=1 after edge 6, c=1 after edge 7. In general c rises after edge DEBOUNCE+3.
  - Falling: p falls after the same delay. c falls only under the retire rule above.
- Wait counter, per road, 8 bits:
  - Clears to 0 when c=0 or RoadN == 4'd1.
  - Otherwise increments by 1 per cycle and saturates at MAX_WAIT; it never wraps.
  - starved[n-1] is registered and high exactly while the counter equals MAX_WAIT.
  - Yellow and red both count as waiting.
- Roads are fully independent. Simultaneous events on all four roads are handled in parallel with identical timing.
- Clear asserted mid-debounce or mid-wait discards all progress. After clear deasserts, detection restarts from sync1, so full latency applies again.

Test Plan:
- Clean arrival (DEBOUNCE=4): Road1=1, Road2..4=0; sensor2 rises and stays high -> c2 goes 1 exactly after edge 7 and holds; c1, c3, c4 stay 0.
- Glitch rejection: sensor3 high for 3 cycles, then low -> p3 and c3 never assert; a 4-cycle pulse (DEBOUNCE+0 synchronized) -> c3 asserts.
- Latch and retire: sensor4 pulse of 10 cycles with Road4=0 -> c4 stays 1 after the sensor drops. Then drive Road4=4'd1 -> c4 falls one edge later. With sensor4 still high during green, c4 stays 1.
- Starvation: MAX_WAIT=5; sensor1 asserted and Road1=0 held -> starved[0] rises 5 edges after c1 rises and stays 1 with no wrap. Road1=4'd1 -> the wait counter and starved[0] clear on the next edge.
- Yellow/red not green: Road2=4'd2 with c2=1 -> c2 holds and the wait counter keeps counting.
- Clear mid-operation: assert clear with c1..c4=1 and counters nonzero -> all outputs 0 after that edge. Release clear with sensors still high -> c reasserts after edge DEBOUNCE+3 counted from release.
